// File: rtl/dvbc_pkg.sv
// Shared DVB-C constants and Forney interleaver geometry helpers.
package dvbc_pkg;

  localparam logic [7:0] DVBC_SYNC_BYTE     = 8'h47;
  localparam logic [7:0] DVBC_SYNC_BYTE_INV = 8'hB8;
  localparam int         DVBC_RS_N          = 204;
  localparam int         DVBC_IL_I          = 12;
  localparam int         DVBC_IL_M          = 17;

  // First RAM word of branch b: branches 1..b-1 occupy M*(1+2+..+(b-1)) words.
  function automatic int il_base(input int b, input int m);
    return m * b * (b - 1) / 2;
  endfunction

  // Total RAM words needed for all delay branches of an I x M interleaver.
  function automatic int il_total(input int i, input int m);
    return m * i * (i - 1) / 2;
  endfunction

endpackage

// File: rtl/dvbc_il_ram.sv
// Single-clock branch memory: combinational read, synchronous write.
module dvbc_il_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; read sees the old word in the cycle it is overwritten.
  // NOTE: the array has no reset so it maps onto RAM; zeroing is done by the owner's clear sweep.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/dvbc_conv_interleaver.sv
// Forney convolutional byte interleaver with RAM clear, bypass and in-band resync.
module dvbc_conv_interleaver
  import dvbc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BRANCHES   = DVBC_IL_I,
  parameter int UNIT_DEPTH = DVBC_IL_M
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             bypass_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             sync_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             sync_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             sync_err_o
);

  localparam int TOTAL = il_total(BRANCHES, UNIT_DEPTH);
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BW    = $clog2(BRANCHES);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       r_state;
  logic [AW-1:0]    r_clr_addr;
  logic [BW-1:0]    r_branch;
  logic [AW-1:0]    r_ptr [BRANCHES];
  logic [WIDTH-1:0] r_data_o;
  logic             r_sync_o;
  logic             r_valid_o;
  logic             r_sync_err;

  logic [AW-1:0]    w_base [BRANCHES];
  logic [AW-1:0]    w_last [BRANCHES];
  logic             w_ready;
  logic             w_accept;
  logic             w_is_b0;
  logic             w_resync;
  logic             w_use_ram;
  logic [AW-1:0]    w_ptr_cur;
  logic [AW-1:0]    w_addr;
  logic [BW-1:0]    w_branch_nxt;
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_addr;
  logic [WIDTH-1:0] w_ram_wdata;
  logic [WIDTH-1:0] w_rdata;

  // Constant per-branch tables: start address and last pointer value (j*M-1).
  for (genvar g = 0; g < BRANCHES; g++) begin : g_tab
    assign w_base[g] = AW'(il_base(g, UNIT_DEPTH));
    if (g == 0) begin : g_b0
      assign w_last[g] = '0;
    end else begin : g_bn
      assign w_last[g] = AW'(g * UNIT_DEPTH - 1);
    end
  end

  assign w_ready      = (r_state == ST_RUN) & (ready_i | ~r_valid_o);
  assign w_accept     = valid_i & w_ready;
  assign w_is_b0      = (r_branch == '0);
  assign w_resync     = w_accept & ~bypass_i & sync_i & ~w_is_b0;
  assign w_use_ram    = w_accept & ~bypass_i & ~sync_i & ~w_is_b0;
  assign w_ptr_cur    = r_ptr[r_branch];
  assign w_addr       = w_base[r_branch] + w_ptr_cur;
  assign w_branch_nxt = (r_branch == BW'(BRANCHES - 1)) ? '0 : r_branch + BW'(1);

  // RAM port mux: the clear sweep owns the memory until RUN.
  // NOTE: every output gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    w_ram_we    = w_use_ram;
    w_ram_addr  = w_addr;
    w_ram_wdata = data_i;
    if (r_state == ST_CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_addr  = r_clr_addr;
      w_ram_wdata = '0;
    end
  end

  dvbc_il_ram #(
    .WIDTH (WIDTH),
    .DEPTH (TOTAL),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_ram_we),
    .waddr_i (w_ram_addr),
    .wdata_i (w_ram_wdata),
    .raddr_i (w_ram_addr),
    .rdata_o (w_rdata)
  );

  // Clear FSM: sweep one word per cycle, then run.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_addr == AW'(TOTAL - 1)) r_state <= ST_RUN;
      else                              r_clr_addr <= r_clr_addr + AW'(1);
    end
  end

  // Commutator and per-branch circular pointers; frozen during bypass.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_branch <= '0;
      for (int b = 0; b < BRANCHES; b++) r_ptr[b] <= '0;
    end else if (w_accept && !bypass_i) begin
      r_branch <= w_resync ? BW'(1) : w_branch_nxt;
      if (w_use_ram) begin
        r_ptr[r_branch] <= (w_ptr_cur == w_last[r_branch]) ? '0 : w_ptr_cur + AW'(1);
      end
    end
  end

  // Single output register: load on accept, drain when downstream takes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data_o  <= '0;
      r_sync_o  <= 1'b0;
      r_valid_o <= 1'b0;
    end else if (w_accept) begin
      r_data_o  <= w_use_ram ? w_rdata : data_i;
      r_sync_o  <= sync_i;
      r_valid_o <= 1'b1;
    end else if (ready_i) begin
      r_valid_o <= 1'b0;
    end
  end

  // One-cycle pulse when a sync byte arrives off branch 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_sync_err <= 1'b0;
    else          r_sync_err <= w_resync;
  end

  assign ready_o    = w_ready;
  assign data_o     = r_data_o;
  assign sync_o     = r_sync_o;
  assign valid_o    = r_valid_o;
  assign busy_o     = (r_state == ST_CLEAR);
  assign sync_err_o = r_sync_err;

endmodule

// File: tb/tb_dvbc_conv_interleaver.sv
// Directed bench for dvbc_conv_interleaver: default I=12/M=17 instance plus a small I=3/M=2 instance.
module tb_dvbc_conv_interleaver;

  logic       clk;
  logic       rst_n;
  logic       bypass_i, sync_i, valid_i, ready_i;
  logic [7:0] data_i;
  logic       ready_o, sync_o, valid_o, busy_o, sync_err_o;
  logic [7:0] data_o;

  logic       s_bypass, s_sync, s_valid, s_ready_i;
  logic [7:0] s_data;
  logic       s_ready_o, s_sync_o, s_valid_o, s_busy_o, s_sync_err_o;
  logic [7:0] s_data_o;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] in_hist   [0:4095];
  logic [7:0] out_hist  [0:4095];
  logic       sync_hist [0:4095];
  logic [7:0] rec       [0:8191];

  logic [7:0] bp_q [$];
  logic       mon_en = 1'b0;
  logic       bp_en  = 1'b0;
  int         bp_unstable = 0;
  int         bp_stalls   = 0;
  logic       prev_stall  = 1'b0;
  logic [7:0] prev_d      = 8'h00;

  dvbc_conv_interleaver dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bypass_i   (bypass_i),
    .data_i     (data_i),
    .sync_i     (sync_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .sync_o     (sync_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .sync_err_o (sync_err_o)
  );

  dvbc_conv_interleaver #(
    .WIDTH      (8),
    .BRANCHES   (3),
    .UNIT_DEPTH (2)
  ) dut_small (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bypass_i   (s_bypass),
    .data_i     (s_data),
    .sync_i     (s_sync),
    .valid_i    (s_valid),
    .ready_o    (s_ready_o),
    .data_o     (s_data_o),
    .sync_o     (s_sync_o),
    .valid_o    (s_valid_o),
    .ready_i    (s_ready_i),
    .busy_o     (s_busy_o),
    .sync_err_o (s_sync_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: always 1 except during the backpressure scenario (30% duty).
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ready_i = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Output monitor for the backpressure scenario.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_o && ready_i) bp_q.push_back(data_o);
      if (prev_stall && (data_o !== prev_d || valid_o !== 1'b1)) bp_unstable <= bp_unstable + 1;
      if (valid_o && !ready_i) bp_stalls <= bp_stalls + 1;
      prev_stall <= valid_o && !ready_i;
      prev_d     <= data_o;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference interleaver for the default config: branch j delays by j*17*12 byte slots.
  function automatic logic [7:0] il_model(input int k);
    int d;
    d = (k % 12) * 204;
    return (k >= d) ? in_hist[k - d] : 8'h00;
  endfunction

  task automatic idle();
    valid_i  = 1'b0;
    sync_i   = 1'b0;
    bypass_i = 1'b0;
    data_i   = 8'h00;
  endtask

  // Offer one byte at a negedge; returns at the negedge after it was accepted.
  task automatic send(input logic [7:0] d, input logic s, input logic byp);
    int n;
    n = 0;
    data_i   = d;
    sync_i   = s;
    bypass_i = byp;
    valid_i  = 1'b1;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout: ready_o stuck at %b, required 1", ready_o);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    int cyc;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (busy_o !== 1'b0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL clear_timeout: busy_o=%b after %0d cycles, required 0", busy_o, cyc);
    end
  endtask

  task automatic test_reset();
    int cyc, s_cyc, rdy_bad;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (data_o !== 8'h00) begin n_mis++; $display("FAIL reset_data_o: got %h, required 00", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_mis++; $display("FAIL reset_valid_o: got %b, required 0", valid_o); end
    n_cmp++; if (sync_o !== 1'b0) begin n_mis++; $display("FAIL reset_sync_o: got %b, required 0", sync_o); end
    n_cmp++; if (sync_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_sync_err_o: got %b, required 0", sync_err_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_mis++; $display("FAIL reset_ready_o: got %b, required 0", ready_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL reset_busy_o: got %b, required 1", busy_o); end
    rst_n   = 1'b1;
    cyc     = 0;
    s_cyc   = 0;
    rdy_bad = 0;
    while (busy_o === 1'b1 && cyc < 3000) begin
      if (ready_o !== 1'b0) rdy_bad++;
      @(negedge clk);
      cyc++;
      if (s_cyc == 0 && s_busy_o === 1'b0) s_cyc = cyc;
    end
    n_cmp++; if (cyc != 1122) begin n_mis++; $display("FAIL clear_length: busy_o fell after %0d cycles, required 1122", cyc); end
    n_cmp++; if (s_cyc != 6) begin n_mis++; $display("FAIL clear_length_small: busy_o fell after %0d cycles, required 6", s_cyc); end
    n_cmp++; if (rdy_bad != 0) begin n_mis++; $display("FAIL ready_during_clear: %0d cycles with ready_o high, required 0", rdy_bad); end
    n_cmp++; if (ready_o !== 1'b1) begin n_mis++; $display("FAIL ready_after_clear: got %b, required 1", ready_o); end
  endtask

  task automatic test_small_config();
    logic [7:0] exp_s [18] = '{8'd1, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd7, 8'd2, 8'd0,
                               8'd10, 8'd5, 8'd0, 8'd13, 8'd8, 8'd3, 8'd16, 8'd11, 8'd6};
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      s_data  = 8'(k + 1);
      s_valid = 1'b1;
      n_cmp++; if (s_ready_o !== 1'b1) begin n_mis++; $display("FAIL small_ready k=%0d: got %b, required 1", k, s_ready_o); end
      @(negedge clk);
      n_cmp++;
      if (s_data_o !== exp_s[k] || s_valid_o !== 1'b1) begin
        n_mis++;
        $display("FAIL small_out k=%0d: got %0d (valid %b), required %0d (valid 1)", k, s_data_o, s_valid_o, exp_s[k]);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_sync_misaligned();
    int nz;
    reset_dut();
    for (int k = 0; k < 5; k++) send(8'(8'h10 + k), 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    n_cmp++; if (data_o !== 8'h55) begin n_mis++; $display("FAIL resync_data: got %h, required 55", data_o); end
    n_cmp++; if (sync_o !== 1'b1) begin n_mis++; $display("FAIL resync_sync_o: got %b, required 1", sync_o); end
    n_cmp++; if (sync_err_o !== 1'b1) begin n_mis++; $display("FAIL resync_err_pulse: got %b, required 1", sync_err_o); end
    send(8'h60, 1'b0, 1'b0);
    n_cmp++; if (sync_err_o !== 1'b0) begin n_mis++; $display("FAIL resync_err_single: got %b, required 0", sync_err_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_mis++; $display("FAIL resync_branch1_out: got %h, required 00", data_o); end
    nz = 0;
    for (int k = 1; k <= 10; k++) begin
      send(8'(8'h60 + k), 1'b0, 1'b0);
      if (data_o !== 8'h00) nz++;
    end
    n_cmp++; if (nz != 0) begin n_mis++; $display("FAIL resync_branches_2_11: %0d nonzero outputs, required 0", nz); end
    send(8'h70, 1'b0, 1'b0);
    n_cmp++; if (data_o !== 8'h70) begin n_mis++; $display("FAIL resync_wrap_branch0: got %h, required 70", data_o); end
    idle();
  endtask

  task automatic test_bypass();
    int nz;
    logic [7:0] byp_v [3] = '{8'hAA, 8'hBB, 8'hCC};
    reset_dut();
    send(8'h21, 1'b0, 1'b0);
    n_cmp++; if (data_o !== 8'h21) begin n_mis++; $display("FAIL bypass_pre_b0: got %h, required 21", data_o); end
    send(8'h22, 1'b0, 1'b0);
    send(8'h23, 1'b0, 1'b0);
    n_cmp++; if (data_o !== 8'h00) begin n_mis++; $display("FAIL bypass_pre_b2: got %h, required 00", data_o); end
    for (int k = 0; k < 3; k++) begin
      send(byp_v[k], 1'b0, 1'b1);
      n_cmp++;
      if (data_o !== byp_v[k] || valid_o !== 1'b1) begin
        n_mis++;
        $display("FAIL bypass_byte%0d: got %h (valid %b), required %h (valid 1)", k, data_o, valid_o, byp_v[k]);
      end
    end
    nz = 0;
    for (int k = 0; k < 9; k++) begin
      send(8'(8'h31 + k), 1'b0, 1'b0);
      if (data_o !== 8'h00) nz++;
    end
    n_cmp++; if (nz != 0) begin n_mis++; $display("FAIL bypass_resume_b3_b11: %0d nonzero outputs, required 0", nz); end
    send(8'h3A, 1'b0, 1'b0);
    n_cmp++; if (data_o !== 8'h3A) begin n_mis++; $display("FAIL bypass_resume_b0: got %h, required 3a", data_o); end
    idle();
  endtask

  task automatic test_backpressure();
    int n, bad;
    reset_dut();
    bp_q.delete();
    bp_unstable = 0;
    bp_stalls   = 0;
    mon_en = 1'b1;
    bp_en  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_hist[k] = 8'(k * 5 + 3);
      send(in_hist[k], 1'b0, 1'b0);
    end
    idle();
    n = 0;
    while (bp_q.size() < 300 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    bp_en = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    n_cmp++; if (bp_q.size() != 300) begin n_mis++; $display("FAIL bp_count: got %0d bytes, required 300", bp_q.size()); end
    bad = 0;
    for (int k = 0; k < 300 && k < bp_q.size(); k++) begin
      if (bp_q[k] !== il_model(k)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL bp_data: %0d bytes differ from model, required 0", bad); end
    n_cmp++; if (bp_unstable != 0) begin n_mis++; $display("FAIL bp_stall_stable: %0d unstable stall cycles, required 0", bp_unstable); end
    n_cmp++; if (bp_stalls == 0) begin n_mis++; $display("FAIL bp_stalls_seen: got %0d stall cycles, required >0", bp_stalls); end
  endtask

  task automatic test_packets();
    int p, i, j, bad, nsync, badsync, nn;
    logic [7:0] d;
    reset_dut();
    for (int k = 0; k < 3876; k++) begin
      if (k < 1632) begin
        p = k / 204;
        i = k % 204;
        d = (i == 0) ? 8'h47 : 8'(p * 31 + i * 7 + 1);
        in_hist[k] = d;
        send(d, (i == 0), 1'b0);
      end else begin
        in_hist[k] = 8'(k);
        send(8'(k), 1'b0, 1'b0);
      end
      out_hist[k]  = data_o;
      sync_hist[k] = sync_o;
    end
    idle();
    for (int m = 0; m < 3876; m++) begin
      j = m % 12;
      rec[m + (11 - j) * 204] = out_hist[m];
    end
    for (int pk = 0; pk < 8; pk++) begin
      bad = 0;
      for (int b = 0; b < 204; b++) begin
        nn = pk * 204 + b;
        if (rec[nn + 2244] !== in_hist[nn]) bad++;
      end
      n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL pkt%0d_deinterleave: %0d bytes differ, required 0", pk, bad); end
    end
    nsync = 0;
    badsync = 0;
    for (int m = 0; m < 3876; m++) begin
      if (sync_hist[m] === 1'b1) begin
        nsync++;
        if (out_hist[m] !== 8'h47 || (m % 204) != 0) badsync++;
      end
    end
    n_cmp++; if (nsync != 8) begin n_mis++; $display("FAIL pkt_sync_count: got %0d, required 8", nsync); end
    n_cmp++; if (badsync != 0) begin n_mis++; $display("FAIL pkt_sync_align: %0d sync_o without 47 at packet start, required 0", badsync); end
  endtask

  initial begin
    rst_n     = 1'b1;
    s_bypass  = 1'b0;
    s_sync    = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    s_ready_i = 1'b1;
    idle();
    test_reset();
    test_small_config();
    test_sync_misaligned();
    test_bypass();
    test_backpressure();
    test_packets();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
